// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port synchronous-read memory between the fetch (I) and load/store (D) ports.
// D has fixed priority; a saturating starvation counter forces one I grant after STARVE_MAX denials.
module mem_port_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              m_en,
  output logic [3:0]        m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {NONE = 2'd0, RSP_I = 2'd1, RSP_D = 2'd2} owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             force_i;

  // Byte-offset and wrapped-away address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

  always_comb begin
    force_i = (starve_q == CNT_W'(STARVE_MAX));
    // Grants are suppressed while reset is held so the macro never sees an access.
    d_gnt   = reset_n & d_req & ~force_i;
    i_gnt   = reset_n & i_req & (~d_req | force_i);
    m_en    = i_gnt | d_gnt;
    m_addr  = d_gnt ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
    m_wdata = d_wdata;
    m_we    = (d_gnt & d_we) ? d_be : 4'b0000;

    owner_d = NONE;
    if (i_gnt)              owner_d = RSP_I;
    else if (d_gnt & ~d_we) owner_d = RSP_D;

    starve_d = starve_q;
    if (~i_req | i_gnt)                       starve_d = '0;
    else if (starve_q != CNT_W'(STARVE_MAX))  starve_d = starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q  <= NONE;
      starve_q <= '0;
    end else begin
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign i_rvalid = (owner_q == RSP_I);
  assign d_rvalid = (owner_q == RSP_D);
  assign i_rdata  = m_rdata;
  assign d_rdata  = m_rdata;

endmodule
